// File: rtl/histo_link_pkg.sv
// Shared definitions for both ends of the histogram UART link: frame geometry,
// error-flag bit positions, FSM state encodings and the debug view of those states.
package histo_link_pkg;

    localparam int NUM_BINS      = 1024;
    localparam int BIN_W         = 24;
    localparam int BYTES_PER_BIN = 3;
    localparam int PIX_W         = BIN_W + 10;

    localparam int ERR_W       = 3;
    localparam int ERR_STOP    = 0;
    localparam int ERR_SHORT   = 1;
    localparam int ERR_OVERRUN = 2;

    typedef enum logic [1:0] {
        HUNT,
        SYNCED,
        ASSEMBLE
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        state_t    frame;
        rx_state_t rx;
    } dbg_t;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: 2-FF line synchroniser, mid-bit sampling, start-glitch and stop-bit
// checks, plus a saturating count of idle-high cycles used for frame-gap detection.
import histo_link_pkg::*;

module uart_byte_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int GAP_LIMIT    = 32 * 434,
    parameter int GAP_W        = $clog2(GAP_LIMIT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             uart_rx,
    output logic             byte_valid,
    output logic [7:0]       byte_data,
    output logic             stop_err,
    output logic [GAP_W-1:0] line_idle_cnt,
    output rx_state_t        rx_state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0] IDLE_MAX  = GAP_W'(GAP_LIMIT);

    logic [1:0]       sync_q;
    logic             rx_s;
    logic             rx_prev;
    logic             fall;
    rx_state_t        state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [2:0]       bit_cnt;
    logic [2:0]       bit_cnt_nx;
    logic [7:0]       shreg;
    logic [7:0]       shreg_nx;
    logic             valid_nx;
    logic             stop_err_nx;

    assign rx_s      = sync_q[1];
    assign fall      = rx_prev & ~rx_s;
    assign byte_data = shreg;

    // Synchroniser and edge history reset to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], uart_rx};
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) rx_state <= RX_IDLE;
        else       rx_state <= state_nx;
    end

    always_comb begin
        state_nx    = rx_state;
        cnt_nx      = cnt;
        bit_cnt_nx  = bit_cnt;
        shreg_nx    = shreg;
        valid_nx    = 1'b0;
        stop_err_nx = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (fall) begin
                    state_nx = RX_START;
                    cnt_nx   = '0;
                end
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nx     = '0;
                    bit_cnt_nx = '0;
                    state_nx   = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nx     = '0;
                    shreg_nx   = {rx_s, shreg[7:1]};
                    bit_cnt_nx = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nx = RX_STOP;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nx      = '0;
                    state_nx    = RX_IDLE;
                    valid_nx    = rx_s;
                    stop_err_nx = ~rx_s;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: state_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            byte_valid    <= 1'b0;
            stop_err      <= 1'b0;
            line_idle_cnt <= '0;
        end else begin
            cnt        <= cnt_nx;
            bit_cnt    <= bit_cnt_nx;
            shreg      <= shreg_nx;
            byte_valid <= valid_nx;
            stop_err   <= stop_err_nx;
            // Any falling edge, even a glitch, restarts the idle measurement.
            if (fall)
                line_idle_cnt <= '0;
            else if (rx_state == RX_IDLE && rx_s && line_idle_cnt != IDLE_MAX)
                line_idle_cnt <= line_idle_cnt + GAP_W'(1);
        end
    end

endmodule

// File: rtl/histo_frame_rx.sv
// Histogram link receiver: frames UART bytes into 24-bit bins, emits one write per bin,
// then reports frame completion with the pixel total, or an abort with sticky error flags.
import histo_link_pkg::*;

module histo_frame_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int NUM_BINS     = histo_link_pkg::NUM_BINS,
    parameter int GAP_BITS     = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        uart_rx,
    output logic                        bin_valid,
    output logic [$clog2(NUM_BINS)-1:0] bin_idx,
    output logic [BIN_W-1:0]            bin_count,
    output logic                        frame_done,
    output logic                        frame_error,
    output logic [PIX_W-1:0]            pixel_total,
    output logic [ERR_W-1:0]            err_flags,
    output dbg_t                        dbg
);

    localparam int IDX_W     = $clog2(NUM_BINS);
    localparam int GAP_LIMIT = GAP_BITS * CLKS_PER_BIT;
    localparam int GAP_W     = $clog2(GAP_LIMIT + 1);

    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             stop_err;
    logic [GAP_W-1:0] line_idle_cnt;
    rx_state_t        rx_state;
    logic             gap_seen;

    state_t           state;
    state_t           state_nx;
    logic [1:0]       byte_idx;
    logic [1:0]       byte_idx_nx;
    logic [IDX_W-1:0] bin_cur;
    logic [IDX_W-1:0] bin_cur_nx;
    logic [BIN_W-1:0] word_q;
    logic [BIN_W-1:0] word_q_nx;
    logic [BIN_W-1:0] word_nx;
    logic [PIX_W-1:0] acc;
    logic [PIX_W-1:0] acc_nx;
    logic             bin_wr;
    logic             last_wr;
    logic             abort;
    logic [ERR_W-1:0] err_set;

    uart_byte_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .GAP_LIMIT    (GAP_LIMIT),
        .GAP_W        (GAP_W)
    ) u_rx (
        .clk           (clk),
        .reset         (reset),
        .uart_rx       (uart_rx),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .stop_err      (stop_err),
        .line_idle_cnt (line_idle_cnt),
        .rx_state      (rx_state)
    );

    assign gap_seen  = (line_idle_cnt == GAP_W'(GAP_LIMIT));
    assign dbg.frame = state;
    assign dbg.rx    = rx_state;

    always_ff @(posedge clk) begin
        if (reset) state <= HUNT;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        byte_idx_nx = byte_idx;
        bin_cur_nx  = bin_cur;
        word_q_nx   = word_q;
        acc_nx      = acc;
        bin_wr      = 1'b0;
        last_wr     = 1'b0;
        abort       = 1'b0;
        err_set     = '0;
        err_set[ERR_STOP] = stop_err;

        // Incoming byte merged into the partial bin, LSB byte first.
        word_nx = (byte_idx == 2'd0) ? '0 : word_q;
        word_nx[{byte_idx, 3'b000} +: 8] = byte_data;

        case (state)
            HUNT: begin
                if (gap_seen) state_nx = SYNCED;
            end
            SYNCED: begin
                if (byte_valid) begin
                    state_nx    = ASSEMBLE;
                    byte_idx_nx = 2'd1;
                    bin_cur_nx  = '0;
                    word_q_nx   = BIN_W'(byte_data);
                    acc_nx      = '0;
                end
            end
            ASSEMBLE: begin
                if (stop_err) begin
                    abort       = 1'b1;
                    byte_idx_nx = '0;
                    state_nx    = HUNT;
                end else if (gap_seen) begin
                    // The gap that cut the frame short is itself a valid sync.
                    abort              = 1'b1;
                    err_set[ERR_SHORT] = 1'b1;
                    byte_idx_nx        = '0;
                    state_nx           = SYNCED;
                end else if (byte_valid) begin
                    word_q_nx = word_nx;
                    if (byte_idx == 2'(BYTES_PER_BIN - 1)) begin
                        bin_wr      = 1'b1;
                        byte_idx_nx = '0;
                        acc_nx      = acc + PIX_W'(word_nx);
                        if (bin_cur == IDX_W'(NUM_BINS - 1)) begin
                            last_wr  = 1'b1;
                            state_nx = HUNT;
                        end else begin
                            bin_cur_nx = bin_cur + IDX_W'(1);
                        end
                    end else begin
                        byte_idx_nx = byte_idx + 2'd1;
                    end
                end
            end
            default: state_nx = HUNT;
        endcase

        // A byte landing while the previous bin write is still on the outputs is an overrun.
        if (byte_valid && bin_valid) begin
            err_set[ERR_OVERRUN] = 1'b1;
            abort                = (state == ASSEMBLE);
            bin_wr               = 1'b0;
            last_wr              = 1'b0;
            byte_idx_nx          = '0;
            state_nx             = HUNT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_idx    <= '0;
            bin_cur     <= '0;
            word_q      <= '0;
            acc         <= '0;
            bin_valid   <= 1'b0;
            bin_idx     <= '0;
            bin_count   <= '0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            pixel_total <= '0;
            err_flags   <= '0;
        end else begin
            byte_idx    <= byte_idx_nx;
            bin_cur     <= bin_cur_nx;
            word_q      <= word_q_nx;
            acc         <= acc_nx;
            bin_valid   <= bin_wr;
            frame_done  <= last_wr;
            frame_error <= abort;
            err_flags   <= err_flags | err_set;
            if (bin_wr) begin
                bin_idx   <= bin_cur;
                bin_count <= word_nx;
            end
            if (last_wr) pixel_total <= acc_nx;
        end
    end

endmodule

// File: tb/tb_histo_frame_rx.sv
// Bench for histo_frame_rx: drives 8N1 frames, gaps, glitches, bad stop bits and resets,
// and checks bin writes, frame strobes, totals and flags against bench-side expectations.
module tb_histo_frame_rx;
    import histo_link_pkg::*;

    localparam int CPB   = 8;
    localparam int NB    = 16;
    localparam int GB    = 32;
    localparam int IDX_W = $clog2(NB);
    localparam int EW    = IDX_W + BIN_W;

    logic             clk;
    logic             reset;
    logic             uart_rx;
    logic             bin_valid;
    logic [IDX_W-1:0] bin_idx;
    logic [BIN_W-1:0] bin_count;
    logic             frame_done;
    logic             frame_error;
    logic [PIX_W-1:0] pixel_total;
    logic [ERR_W-1:0] err_flags;
    dbg_t             dbg;

    histo_frame_rx #(
        .CLKS_PER_BIT (CPB),
        .NUM_BINS     (NB),
        .GAP_BITS     (GB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .uart_rx     (uart_rx),
        .bin_valid   (bin_valid),
        .bin_idx     (bin_idx),
        .bin_count   (bin_count),
        .frame_done  (frame_done),
        .frame_error (frame_error),
        .pixel_total (pixel_total),
        .err_flags   (err_flags),
        .dbg         (dbg)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc++;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0]    exp_q[$];
    logic [BIN_W-1:0] cnt_tab[NB];
    logic [PIX_W-1:0] exp_total = '0;
    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int last_bv_cyc = -100;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (dut.u_rx.byte_valid) last_bv_cyc = cyc;
        if (bin_valid) begin
            check("bin_latency", cyc - last_bv_cyc, 1);
            check("bin_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("bin_idx", bin_idx, e[EW-1:BIN_W]);
                check("bin_count", bin_count, e[BIN_W-1:0]);
            end
        end
        if (frame_done || frame_error)
            check("done_err_excl", frame_done & frame_error, 1'b0);
        if (frame_done) begin
            done_cnt++;
            check("done_total", pixel_total, exp_total);
            check("done_last_bin", {bin_valid, bin_idx}, {1'b1, IDX_W'(NB - 1)});
        end
        if (frame_error) ferr_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic idle_bits(input int n);
        uart_rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send_bit(input logic v);
        uart_rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop_ok);
        idle_bits((stop_ok ? 0 : 1) + int'($urandom_range(0, 2)));
    endtask

    task automatic glitch();
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic fill_random();
        for (int b = 0; b < NB; b++) begin
            case ($urandom_range(0, 7))
                0:       cnt_tab[b] = '0;
                1:       cnt_tab[b] = 24'hFFFFFF;
                default: cnt_tab[b] = BIN_W'($urandom);
            endcase
        end
    endtask

    task automatic send_bins(input int n);
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k < BYTES_PER_BIN; k++) begin
                if (k == BYTES_PER_BIN - 1) exp_q.push_back({IDX_W'(b), cnt_tab[b]});
                send_byte(cnt_tab[b][8*k +: 8], 1'b1);
            end
        end
    endtask

    task automatic send_frame();
        exp_total = '0;
        for (int b = 0; b < NB; b++) exp_total += PIX_W'(cnt_tab[b]);
        send_bins(NB);
    endtask

    task automatic scenario_check(input string tag, input int exp_done, input int exp_ferr,
                                  input logic [ERR_W-1:0] exp_flags, input state_t exp_state);
        check({tag, "_done"}, done_cnt, exp_done);
        check({tag, "_ferr"}, ferr_cnt, exp_ferr);
        check({tag, "_bins_left"}, exp_q.size(), 0);
        check({tag, "_total"}, pixel_total, exp_total);
        check({tag, "_flags"}, err_flags, exp_flags);
        check({tag, "_state"}, dbg.frame, exp_state);
        done_cnt = 0;
        ferr_cnt = 0;
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset   = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_strobes", {bin_valid, frame_done, frame_error}, 3'b000);
        check("rst_bin", {bin_idx, bin_count}, '0);
        check("rst_total", pixel_total, '0);
        check("rst_flags", err_flags, '0);
        check("rst_state", dbg.frame, HUNT);

        // Sync, then a frame with bin i = i+1.
        idle_bits(40);
        check("sync_state", dbg.frame, SYNCED);
        for (int b = 0; b < NB; b++) cnt_tab[b] = BIN_W'(b + 1);
        send_frame();
        idle_bits(2);
        check("ramp_total_value", pixel_total, PIX_W'(NB * (NB + 1) / 2));
        scenario_check("ramp", 1, 0, 3'b000, HUNT);

        // Glitch in HUNT restarts the gap count; then a glitch in SYNCED changes nothing.
        idle_bits(18);
        glitch();
        idle_bits(20);
        check("glitch_hunt_state", dbg.frame, HUNT);
        idle_bits(20);
        check("glitch_hunt_sync", dbg.frame, SYNCED);
        glitch();
        idle_bits(4);
        check("glitch_rx_idle", dbg.rx, RX_IDLE);
        scenario_check("glitch", 0, 0, 3'b000, SYNCED);

        // Random frame with boundary counts and the 0x123456 bin.
        fill_random();
        cnt_tab[0] = '0;
        cnt_tab[1] = 24'hFFFFFF;
        cnt_tab[5] = 24'h123456;
        send_frame();
        idle_bits(2);
        scenario_check("rand", 1, 0, 3'b000, HUNT);

        // Short frame: gap after 8 complete bins, then a full frame with no extra gap.
        idle_bits(40);
        fill_random();
        send_bins(NB / 2);
        idle_bits(40);
        scenario_check("short", 0, 1, 3'b010, SYNCED);
        fill_random();
        send_frame();
        idle_bits(2);
        scenario_check("after_short", 1, 0, 3'b010, HUNT);

        // Bad stop bit inside bin 10; following bytes before a gap yield nothing.
        idle_bits(40);
        fill_random();
        send_bins(10);
        send_byte(8'h5A, 1'b1);
        send_byte(8'hC3, 1'b0);
        idle_bits(2);
        scenario_check("stop_err", 0, 1, 3'b011, HUNT);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1);
        idle_bits(2);
        scenario_check("stop_drop", 0, 0, 3'b011, HUNT);
        idle_bits(40);
        fill_random();
        send_frame();
        idle_bits(2);
        scenario_check("after_stop", 1, 0, 3'b011, HUNT);

        // One-cycle reset in the middle of bin 8.
        idle_bits(40);
        fill_random();
        send_bins(8);
        send_byte(cnt_tab[8][7:0], 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        uart_rx = 1'b1;
        @(negedge clk);
        check("mid_rst_strobes", {bin_valid, frame_done, frame_error}, 3'b000);
        check("mid_rst_bin", {bin_idx, bin_count}, '0);
        check("mid_rst_total", pixel_total, '0);
        check("mid_rst_flags", err_flags, '0);
        check("mid_rst_state", dbg, {HUNT, RX_IDLE});
        exp_q.delete();
        done_cnt  = 0;
        ferr_cnt  = 0;
        exp_total = '0;
        idle_bits(40);
        fill_random();
        send_frame();
        idle_bits(2);
        scenario_check("after_rst", 1, 0, 3'b000, HUNT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
